// File: rtl/regbank_pkg.sv
// regbank_pkg: shared types and default sizes for the register-bank arbiter.
package regbank_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_NREG   = 4;
    localparam int DEF_ADDR_W = 2;
endpackage

// File: rtl/regbank_arbiter_if.sv
// regbank_arbiter_if: requester handshakes plus the register-bank bus.
interface regbank_arbiter_if
    import regbank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG,
    parameter int ADDR_W = DEF_ADDR_W
) ();
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, done0, done1;
    logic [DATA_W-1:0] rdata;
    logic [NREG-1:0]   bank_cs;
    logic              bank_w, bank_r;
    logic [DATA_W-1:0] bank_din, bank_dout;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bank_dout,
        input  gnt0, gnt1, done0, done1, rdata, bank_cs, bank_w, bank_r, bank_din
    );
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bank_dout,
        output gnt0, gnt1, done0, done1, rdata, bank_cs, bank_w, bank_r, bank_din
    );
endinterface

// File: rtl/regbank_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; ptr_i names the side that wins a tie.
module rr_arbiter2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    output logic valid_o,
    output logic win_o
);
    assign valid_o = req0_i || req1_i;
    assign win_o   = (req0_i && req1_i) ? ptr_i : req1_i;
endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: round-robin sharing of a register bank between two requesters,
// sequencing one cs/w/r access per transaction and pulsing done to the owner.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic              clk,
    input logic              rst_n,
    regbank_arbiter_if.slave bus
);
    state_e            state_q, state_d;
    logic              ptr_q, ptr_d, win_q, win_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              pick_valid, pick_win, in_range, access;

    rr_arbiter2 u_rr (
        .req0_i  (bus.req0),
        .req1_i  (bus.req1),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    assign in_range = {1'b0, addr_q} < (ADDR_W + 1)'(NREG);
    assign access   = state_q == ACCESS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (pick_valid) begin
                state_d = ACCESS;
                win_d   = pick_win;
                we_d    = pick_win ? bus.we1 : bus.we0;
                addr_d  = pick_win ? bus.addr1 : bus.addr0;
                wdata_d = pick_win ? bus.wdata1 : bus.wdata0;
            end
            // The bus floats when nothing is selected, so out-of-range reads return 0 explicitly.
            ACCESS: begin
                state_d = DONE;
                if (!we_q) rdata_d = in_range ? bus.bank_dout : '0;
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = !win_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0     = state_q != IDLE && !win_q;
    assign bus.gnt1     = state_q != IDLE && win_q;
    assign bus.done0    = state_q == DONE && !win_q;
    assign bus.done1    = state_q == DONE && win_q;
    assign bus.bank_cs  = (access && in_range) ? NREG'(1) << addr_q : '0;
    assign bus.bank_w   = access && we_q;
    assign bus.bank_r   = access && !we_q;
    assign bus.bank_din = bus.bank_w ? wdata_q : '0;
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter: directed checks of arbitration, access sequencing and reset,
// against a three-register bank model (address 3 is out of range).
module tb_regbank_arbiter;
    import regbank_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_asserts = 0;
    int   n_fail = 0;
    logic [15:0] regs [3] = '{default: 16'h0000};

    always #5 clk = ~clk;

    regbank_arbiter_if #(.DATA_W(16), .NREG(3), .ADDR_W(2)) bus ();

    regbank_arbiter #(.DATA_W(16), .NREG(3), .ADDR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Unselected bus reads as garbage so that a missing zero-substitution shows up.
    always @(posedge clk)
        for (int i = 0; i < 3; i++) if (bus.bank_w && bus.bank_cs[i]) regs[i] <= bus.bank_din;
    assign bus.bank_dout = (bus.bank_r && bus.bank_cs != 3'b000) ?
        regs[bus.bank_cs[1] ? 1 : bus.bank_cs[2] ? 2 : 0] : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic r, input logic w, input logic [1:0] a,
                         input logic [15:0] wd);
        if (s) begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = wd;
        end else begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = wd;
        end
    endtask

    task automatic xact(input string tag, input bit s, input logic w, input logic [1:0] a,
                        input logic [15:0] wd, input logic [2:0] exp_cs, input logic [15:0] exp_rd);
        drive(s, 1'b1, w, a, wd);
        @(negedge clk);
        check({tag, "_acc_gnt"}, {bus.gnt1, bus.gnt0}, s ? 2'b10 : 2'b01);
        check({tag, "_acc_cs"}, bus.bank_cs, exp_cs);
        check({tag, "_acc_wr"}, {bus.bank_w, bus.bank_r}, w ? 2'b10 : 2'b01);
        check({tag, "_acc_din"}, bus.bank_din, w ? wd : 16'h0000);
        check({tag, "_acc_done"}, {bus.done1, bus.done0}, 2'b00);
        drive(s, 1'b0, 1'b0, 2'd0, 16'h0000);
        @(negedge clk);
        check({tag, "_dn_done"}, {bus.done1, bus.done0}, s ? 2'b10 : 2'b01);
        check({tag, "_dn_gnt"}, {bus.gnt1, bus.gnt0}, s ? 2'b10 : 2'b01);
        check({tag, "_dn_bus"}, {bus.bank_cs, bus.bank_w, bus.bank_r}, 5'b0);
        check({tag, "_dn_rdata"}, bus.rdata, exp_rd);
        @(negedge clk);
        check({tag, "_idle"}, {bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 4'b0);
    endtask

    always @(negedge clk) if (rst_n) begin
        check("inv_cs_onehot0", 32'($onehot0(bus.bank_cs)), 1);
        check("inv_w_and_r", bus.bank_w && bus.bank_r, 0);
        check("inv_gnt_both", bus.gnt0 && bus.gnt1, 0);
        check("inv_done0", bus.done0 && !(bus.gnt0 && !bus.bank_w && !bus.bank_r), 0);
        check("inv_done1", bus.done1 && !(bus.gnt1 && !bus.bank_w && !bus.bank_r), 0);
        check("inv_bank_idle", (bus.bank_w || bus.bank_r) && !(bus.gnt0 || bus.gnt1), 0);
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
        repeat (2) @(negedge clk);
        check("rst_gnt_done", {bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 4'b0);
        check("rst_rdata", bus.rdata, 16'h0000);
        check("rst_bank", {bus.bank_cs, bus.bank_w, bus.bank_r, bus.bank_din}, 21'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // req1 alone with pointer at 0 is granted immediately
        xact("t4_wr", 1'b1, 1'b1, 2'd0, 16'h1234, 3'b001, 16'h0000);
        check("t4_reg0", regs[0], 16'h1234);

        xact("t2_wr", 1'b0, 1'b1, 2'd2, 16'hA5A5, 3'b100, 16'h0000);
        check("t2_reg2", regs[2], 16'hA5A5);
        xact("t2_rd", 1'b0, 1'b0, 2'd2, 16'h0000, 3'b100, 16'hA5A5);
        xact("t4_rd", 1'b1, 1'b0, 2'd0, 16'h0000, 3'b001, 16'h1234);

        // both held: pointer is 0 now, so grants go 0,1,0,1,...
        drive(1'b0, 1'b1, 1'b1, 2'd0, 16'h1111);
        drive(1'b1, 1'b1, 1'b1, 2'd1, 16'h2222);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t3_acc_gnt", {bus.gnt1, bus.gnt0}, (k % 2) ? 2'b10 : 2'b01);
            check("t3_acc_cs", bus.bank_cs, (k % 2) ? 3'b010 : 3'b001);
            @(negedge clk);
            check("t3_done", {bus.done1, bus.done0}, (k % 2) ? 2'b10 : 2'b01);
            check("t3_rdata_hold", bus.rdata, 16'h1234);
            @(negedge clk);
            check("t3_idle", {bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 4'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
        check("t3_reg0", regs[0], 16'h1111);
        check("t3_reg1", regs[1], 16'h2222);
        xact("t3_rd", 1'b0, 1'b0, 2'd1, 16'h0000, 3'b010, 16'h2222);

        // address 3 is outside the bank
        xact("t5_rd", 1'b0, 1'b0, 2'd3, 16'h0000, 3'b000, 16'h0000);
        xact("t5_wr", 1'b0, 1'b1, 2'd3, 16'hBEEF, 3'b000, 16'h0000);
        check("t5_reg0", regs[0], 16'h1111);
        check("t5_reg1", regs[1], 16'h2222);
        check("t5_reg2", regs[2], 16'hA5A5);

        xact("t1_pre", 1'b0, 1'b0, 2'd0, 16'h0000, 3'b001, 16'h1111);
        drive(1'b0, 1'b1, 1'b1, 2'd2, 16'h5A5A);
        @(negedge clk);
        check("t1_acc_w", {bus.bank_cs, bus.bank_w}, 4'b1001);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_gnt_done", {bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 4'b0);
        check("t1_rst_bank", {bus.bank_cs, bus.bank_w, bus.bank_r, bus.bank_din}, 21'b0);
        check("t1_rst_rdata", bus.rdata, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        @(negedge clk);
        check("t1_reg2_kept", regs[2], 16'hA5A5);
        rst_n = 1'b1;

        // pointer was 1 before reset; reset returns the tie to req0
        drive(1'b0, 1'b1, 1'b0, 2'd2, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 2'd1, 16'h0000);
        @(negedge clk);
        check("t1_ptr_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
        @(negedge clk);
        check("t1_post_rdata", bus.rdata, 16'hA5A5);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
